// File: rtl/vrf_wr_arb.sv
// Two-requester round-robin arbiter for the vector register file write port.
// The winner streams LANES elements into one register, one element per accepted beat.
module vrf_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4,
  localparam int ADDR_B    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
  localparam int ELEM_B    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_i,
  input  logic [ADDR_B-1:0]     addr0_i,
  input  logic [ADDR_B-1:0]     addr1_i,
  input  logic [1:0]            valid_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic [1:0]            ready_o,
  output logic [1:0]            gnt_o,
  output logic [1:0]            done_o,
  output logic                  vrf_wr_req_o,
  output logic                  vrf_wr_en_o,
  output logic                  vrf_wr_ready_o,
  output logic [ADDR_B-1:0]     vrf_wr_addr_o,
  output logic [ELEM_B-1:0]     vrf_wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0] vrf_wdata_o,
  output logic                  busy_o
);

  localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

  typedef enum logic [1:0] {IDLE, START, WRITE} state_t;

  state_t              r_state, w_nextState;
  logic                r_last, w_nextLast;
  logic [ELEM_B-1:0]   r_cnt, w_nextCnt;
  logic [ADDR_B-1:0]   r_addr, w_nextAddr;

  logic                w_pick;
  logic                w_winnerValid;
  logic                w_beat;
  logic                w_lastBeat;
  logic [1:0]          w_ownerHot;

  // r_last doubles as the current owner: it is updated on every grant.
  assign w_pick        = (req_i == 2'b11) ? ~r_last : req_i[1];
  assign w_ownerHot    = r_last ? 2'b10 : 2'b01;
  assign w_winnerValid = r_last ? valid_i[1] : valid_i[0];
  assign w_beat        = (r_state == WRITE) && w_winnerValid;
  assign w_lastBeat    = w_beat && (r_cnt == LAST_ELEM);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
      r_cnt   <= w_nextCnt;
      r_addr  <= w_nextAddr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextLast  = r_last;
    w_nextCnt   = r_cnt;
    w_nextAddr  = r_addr;
    case (r_state)
      IDLE: begin
        if (req_i != 2'b00) begin
          w_nextLast  = w_pick;
          w_nextAddr  = w_pick ? addr1_i : addr0_i;
          w_nextState = START;
        end
      end
      START: w_nextState = WRITE;
      WRITE: begin
        if (w_beat) begin
          w_nextCnt = w_lastBeat ? '0 : r_cnt + 1'b1;
          if (w_lastBeat) w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign busy_o            = (r_state != IDLE);
  assign gnt_o             = busy_o ? w_ownerHot : 2'b00;
  assign ready_o           = (r_state == WRITE) ? w_ownerHot : 2'b00;
  assign vrf_wr_req_o      = (r_state == START);
  assign vrf_wr_en_o       = w_beat;
  assign vrf_wr_ready_o    = w_lastBeat;
  assign done_o            = w_lastBeat ? w_ownerHot : 2'b00;
  assign vrf_wr_addr_o     = r_addr;
  assign vrf_wr_elem_cnt_o = r_cnt;
  // The loser's data never reaches the write port, and the bus stays zero between beats.
  assign vrf_wdata_o       = w_beat ? (r_last ? data1_i : data0_i) : '0;

endmodule

// File: tb/tb_vrf_wr_arb.sv
// Scoreboard bench for vrf_wr_arb: the stimulus process queues expected transaction
// starts and element writes; a negedge monitor pops and compares them as the DUT emits them.
module tb_vrf_wr_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [4:0]  addr0_i, addr1_i;
  logic [1:0]  valid_i;
  logic [31:0] data0_i, data1_i;
  logic [1:0]  ready_o, gnt_o, done_o;
  logic        vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o, busy_o;
  logic [4:0]  vrf_wr_addr_o;
  logic [1:0]  vrf_wr_elem_cnt_o;
  logic [31:0] vrf_wdata_o;

  vrf_wr_arb dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .valid_i(valid_i),
    .data0_i(data0_i), .data1_i(data1_i),
    .ready_o(ready_o), .gnt_o(gnt_o), .done_o(done_o),
    .vrf_wr_req_o(vrf_wr_req_o), .vrf_wr_en_o(vrf_wr_en_o),
    .vrf_wr_ready_o(vrf_wr_ready_o), .vrf_wr_addr_o(vrf_wr_addr_o),
    .vrf_wr_elem_cnt_o(vrf_wr_elem_cnt_o), .vrf_wdata_o(vrf_wdata_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic who; logic [4:0] addr; } st_t;
  typedef struct packed { logic who; logic [4:0] addr; logic [1:0] elem; logic [31:0] data; logic last; } wr_t;

  st_t         startQ[$];
  wr_t         wrQ[$];
  logic [31:0] src0[$], src1[$];
  bit          en0, en1;
  bit          take0, take1, sawReq, sawDone;
  int          doneCount = 0;
  int          compared = 0, mismatched = 0;
  int          cyc, reqAt, dc;
  st_t         monS;
  wr_t         monW;

  function automatic logic [1:0] oh(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Valid/data for each requester come from its source queue, gated by en0/en1.
  task automatic applyStimulus();
    valid_i[0] = en0 && (src0.size() != 0);
    valid_i[1] = en1 && (src1.size() != 0);
    data0_i    = (src0.size() != 0) ? src0[0] : 32'hBAD0_0000;
    data1_i    = (src1.size() != 0) ? src1[0] : 32'hBAD1_0000;
  endtask

  task automatic step();
    @(negedge clk_i);
    take0   = ready_o[0] & valid_i[0];
    take1   = ready_o[1] & valid_i[1];
    sawReq  = vrf_wr_req_o;
    sawDone = |done_o;
    if (sawDone) doneCount++;
    @(posedge clk_i);
    #1;
    if (take0 && src0.size() != 0) void'(src0.pop_front());
    if (take1 && src1.size() != 0) void'(src1.pop_front());
    applyStimulus();
  endtask

  task automatic expectXfer(input logic who, input logic [4:0] addr, input logic [31:0] base);
    startQ.push_back('{who: who, addr: addr});
    for (int e = 0; e < 4; e++) begin
      wrQ.push_back('{who: who, addr: addr, elem: 2'(e), data: base + 32'(e), last: (e == 3)});
      if (who) src1.push_back(base + 32'(e));
      else     src0.push_back(base + 32'(e));
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, {15'd0, gnt_o, ready_o, done_o, vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o,
                       vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o, busy_o}, 64'd0);
  endtask

  // Cycle 1 is the IDLE cycle in which the request is first seen.
  task automatic run(input int nDones, input int dropAt, input int stallAt, input int stallLen,
                     output int cycles, output int reqCycle);
    int got = 0;
    cycles   = 0;
    reqCycle = 0;
    while (got < nDones && cycles < 100) begin
      step();
      cycles++;
      if (sawReq && reqCycle == 0) reqCycle = cycles;
      if (sawDone) got++;
      if (cycles == dropAt) begin
        req_i   = 2'b00;
        addr0_i = 5'd12;
        addr1_i = 5'd13;
      end
      if (stallLen > 0 && cycles == stallAt) en0 = 1'b0;
      if (stallLen > 0 && cycles == stallAt + 1)
        checkOutput("stall holds count", {61'd0, vrf_wr_en_o, vrf_wr_elem_cnt_o}, {61'd0, 1'b0, 2'd2});
      if (stallLen > 0 && cycles == stallAt + stallLen) en0 = 1'b1;
      applyStimulus();
    end
    if (got < nDones) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: got %0d done pulses, want %0d", got, nDones);
    end
    req_i = 2'b00;
    applyStimulus();
  endtask

  // Monitor: pops the scoreboard on every start pulse and every write beat.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (vrf_wr_req_o) begin
        if (startQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected start: addr %h, want no start", vrf_wr_addr_o);
        end else begin
          monS = startQ.pop_front();
          checkOutput("start", {53'd0, gnt_o, vrf_wr_addr_o, ready_o, busy_o, vrf_wr_en_o},
                      {53'd0, oh(monS.who), monS.addr, 2'b00, 1'b1, 1'b0});
        end
      end
      if (vrf_wr_en_o) begin
        if (wrQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected beat: data %h, want no beat", vrf_wdata_o);
        end else begin
          monW = wrQ.pop_front();
          checkOutput($sformatf("beat elem%0d", monW.elem),
                      {20'd0, gnt_o, vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o, vrf_wr_ready_o, done_o},
                      {20'd0, oh(monW.who), monW.addr, monW.elem, monW.data, monW.last,
                       monW.last ? oh(monW.who) : 2'b00});
        end
      end else begin
        checkOutput("no-beat strobes", {29'd0, vrf_wr_ready_o, done_o, vrf_wdata_o}, 64'd0);
      end
      if (!busy_o)
        checkOutput("idle grant", {59'd0, gnt_o, ready_o, vrf_wr_req_o}, 64'd0);
    end
  end

  initial begin
    rst_i = 1'b1; req_i = 2'b00; addr0_i = '0; addr1_i = '0;
    en0 = 1'b0; en1 = 1'b0;
    applyStimulus();
    repeat (2) @(posedge clk_i);
    #1;
    checkResetOutputs("reset outputs");
    rst_i = 1'b0;

    // Tie from reset goes to requester 0, then strict alternation with one IDLE gap.
    addr0_i = 5'd3; addr1_i = 5'd17;
    expectXfer(1'b0, 5'd3,  32'h1000_0000);
    expectXfer(1'b1, 5'd17, 32'h2000_0000);
    expectXfer(1'b0, 5'd3,  32'h1000_0010);
    expectXfer(1'b1, 5'd17, 32'h2000_0010);
    en0 = 1'b1; en1 = 1'b1; req_i = 2'b11;
    applyStimulus();
    run(4, 0, 0, 0, cyc, reqAt);
    checkOutput("alternate cycles", 64'(cyc), 64'd24);
    checkOutput("alternate req latency", 64'(reqAt), 64'd2);

    // Single request, valid held.
    addr0_i = 5'd5;
    expectXfer(1'b0, 5'd5, 32'h3000_0000);
    req_i = 2'b01;
    applyStimulus();
    run(1, 1, 0, 0, cyc, reqAt);
    checkOutput("single cycles", 64'(cyc), 64'd6);
    checkOutput("single req latency", 64'(reqAt), 64'd2);

    // Two-cycle valid stall after element 1.
    addr0_i = 5'd6;
    expectXfer(1'b0, 5'd6, 32'h4000_0000);
    req_i = 2'b01;
    applyStimulus();
    run(1, 1, 4, 2, cyc, reqAt);
    checkOutput("stall cycles", 64'(cyc), 64'd8);

    // Request and addresses dropped mid-transfer; transfer still completes at the old address.
    addr0_i = 5'd8;
    expectXfer(1'b0, 5'd8, 32'h5000_0000);
    req_i = 2'b01;
    applyStimulus();
    run(1, 3, 0, 0, cyc, reqAt);
    checkOutput("drop cycles", 64'(cyc), 64'd6);

    // Requester 1 pattern at top register while requester 0 waves junk data.
    addr1_i = 5'd31;
    expectXfer(1'b1, 5'd31, 32'hA000_0000);
    for (int i = 0; i < 4; i++) src0.push_back(32'hDEAD_0000 + 32'(i));
    en0 = 1'b1; req_i = 2'b10;
    applyStimulus();
    run(1, 1, 0, 0, cyc, reqAt);
    checkOutput("pattern cycles", 64'(cyc), 64'd6);
    checkOutput("loser data untouched", 64'(src0.size()), 64'd4);
    src0.delete();
    applyStimulus();

    // Reset during element 2: no done, outputs clear at once, next tie goes to requester 0.
    addr0_i = 5'd7;
    startQ.push_back('{who: 1'b0, addr: 5'd7});
    wrQ.push_back('{who: 1'b0, addr: 5'd7, elem: 2'd0, data: 32'h6000_0000, last: 1'b0});
    wrQ.push_back('{who: 1'b0, addr: 5'd7, elem: 2'd1, data: 32'h6000_0001, last: 1'b0});
    for (int i = 0; i < 4; i++) src0.push_back(32'h6000_0000 + 32'(i));
    req_i = 2'b01;
    applyStimulus();
    dc = doneCount;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) begin
        req_i = 2'b00;
        applyStimulus();
      end
    end
    rst_i = 1'b1;
    #1;
    checkResetOutputs("mid-write reset outputs");
    step();
    rst_i = 1'b0;
    src0.delete();
    applyStimulus();
    checkOutput("no done after reset", 64'(doneCount), 64'(dc));
    addr0_i = 5'd9; addr1_i = 5'd10;
    expectXfer(1'b0, 5'd9,  32'h7000_0000);
    expectXfer(1'b1, 5'd10, 32'h8000_0000);
    req_i = 2'b11;
    applyStimulus();
    run(2, 0, 0, 0, cyc, reqAt);
    checkOutput("post-reset tie cycles", 64'(cyc), 64'd12);

    repeat (3) step();
    checkOutput("start queue drained", 64'(startQ.size()), 64'd0);
    checkOutput("write queue drained", 64'(wrQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vrf_wr_arb.md
VRF_WR_ARB -- requirements
Module: vrf_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one vector element.
REQ-002 SHALL have parameter REG_NUM, default 32, number of vector registers; ADDR_B = clog2(REG_NUM).
REQ-003 SHALL have parameter LANES, default 4, elements per register write (one per bank); ELEM_B = clog2(LANES).
REQ-004 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  2  bit N: requester N asks for the VRF write port.
REQ-007 SHALL have port addr0_i / addr1_i  input  ADDR_B each  destination register of requester 0 / 1.
REQ-008 SHALL have port valid_i  input  2  bit N: requester N presents an element on dataN_i.
REQ-009 SHALL have port data0_i / data1_i  input  DATA_WIDTH each  element data of requester 0 / 1.
REQ-010 SHALL have port ready_o  output  2  bit N: element from requester N accepted this cycle if valid.
REQ-011 SHALL have port gnt_o  output  2  bit N: requester N owns the write port (one-hot or zero).
REQ-012 SHALL have port done_o  output  2  bit N: one-cycle pulse, last element of requester N written.
REQ-013 SHALL have port vrf_wr_req_o  output  1  one-cycle pulse opening a VRF write transaction.
REQ-014 SHALL have port vrf_wr_en_o  output  1  write strobe for the current element.
REQ-015 SHALL have port vrf_wr_ready_o  output  1  closes the VRF write transaction.
REQ-016 SHALL have ports vrf_wr_addr_o (ADDR_B), vrf_wr_elem_cnt_o (ELEM_B), vrf_wdata_o (DATA_WIDTH)  output  VRF write address, element/bank index, write data.
REQ-017 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, START, WRITE; a round-robin pointer last_q (1 bit, winner of last grant); element counter cnt_q (ELEM_B bits).
REQ-019 IDLE: if exactly one req_i bit set, that requester SHALL win; if both set, the requester != last_q SHALL win; winner index, addr latched into vrf_wr_addr_o register, last_q updated, next state START.
REQ-020 IDLE with req_i == 0 SHALL remain IDLE with all strobes low.
REQ-021 START: vrf_wr_req_o SHALL be 1 for exactly this one cycle, ready_o = 0; next state WRITE unconditionally.
REQ-022 gnt_o SHALL be one-hot on the winner during START and WRITE, and 0 in IDLE.
REQ-023 WRITE: ready_o bit of winner SHALL be 1; beat = valid & ready of winner; on beat vrf_wr_en_o = 1, vrf_wr_elem_cnt_o = cnt_q, vrf_wdata_o = winner data (combinational), cnt_q increments.
REQ-024 WRITE with winner valid low SHALL hold cnt_q, drive vrf_wr_en_o = 0, no timeout.
REQ-025 Beat with cnt_q == LANES-1: vrf_wr_ready_o = 1 and done_o bit of winner = 1 in the same cycle, cnt_q wraps to 0, next state IDLE.
REQ-026 vrf_wdata_o SHALL be 0 and vrf_wr_elem_cnt_o SHALL equal cnt_q outside WRITE beats; losing requester's valid/data SHALL be ignored.
REQ-027 Deassertion of the winner's req_i during START/WRITE SHALL NOT abort; transfer completes after LANES beats.
REQ-028 Latency: req at IDLE cycle t -> gnt_o and vrf_wr_req_o at t+1, ready_o at t+2; minimum LANES+2 cycles per transfer; at least one IDLE cycle between transfers.
REQ-029 addr changes on addrN_i after grant SHALL NOT affect vrf_wr_addr_o until next grant.

Reset
REQ-030 rst_i high SHALL immediately force IDLE, cnt_q = 0, last_q = 1 (requester 0 wins first tie), vrf_wr_addr_o = 0, all outputs 0.
REQ-031 rst_i during START/WRITE SHALL abandon the transfer without emitting vrf_wr_ready_o or done_o.

Verification
REQ-032 Single req_i=01, addr0=5, valid0 held 1 -> vrf_wr_req_o at t+1, wr_en on elem 0,1,2,3 at t+2..t+5, wr_ready and done_o=01 at t+5, addr 5 throughout.
REQ-033 req_i=11 from reset -> requester 0 served first, then requester 1 after one IDLE cycle; repeat with both held -> alternates 0,1,0,1.
REQ-034 valid0 low for 2 cycles after elem 1 -> wr_en low those cycles, elem_cnt stays 2, total transfer 8 cycles, data order preserved.
REQ-035 req0 dropped at t+3 -> transfer still completes 4 beats, done_o=01.
REQ-036 rst_i pulsed mid-WRITE at elem 2 -> all outputs 0 same cycle, no done_o; next req_i=11 grants requester 0.
REQ-037 Pattern data 0xA000_0000+elem for requester 1, addr1=31 -> vrf_wdata_o matches per elem_cnt, requester 0 data never appears.
